// File: rtl/vga_frame_scanner_if.sv
// vga_frame_scanner_if
// Groups the CPU cell-write port and the VGA connector signals of the frame
// scanner.
//   wr_en       one-clock write strobe from the CPU VGA instruction
//   wr_x        cell column, 0..79
//   wr_y        cell row, 0..59
//   wr_color    {R,G,B} colour for the addressed cell
//   vga_hs      horizontal sync, active-low
//   vga_vs      vertical sync, active-low
//   vga_r/g/b   colour outputs
//   frame_start one-clock pulse when the scan wraps to (0,0)
// master: CPU / stimulus side.  slave: the scanner.
interface vga_frame_scanner_if;
   logic       wr_en;
   logic [6:0] wr_x;
   logic [5:0] wr_y;
   logic [2:0] wr_color;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_r;
   logic       vga_g;
   logic       vga_b;
   logic       frame_start;

   modport master (
      output wr_en, wr_x, wr_y, wr_color,
      input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_color,
      output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
   );
endinterface

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner
// Stores 3-bit colour cells written by the CPU into an 80x60 frame buffer
// and scans it out as 640x480@60 VGA, each cell drawn as an 8x8 pixel block.
// The pixel rate is half of clk_sys; counters, pipeline and outputs move only
// on tick cycles, while cell writes are taken on any clock.
// Ports:
//   clk    system clock (50 MHz)
//   rst_n  asynchronous active-low reset
//   bus    vga_frame_scanner_if.slave (write port in, VGA signals out)
// Optional build macro VGA_GRID_EN: draws white cell outlines during active
// video (pixel x[2:0]==0 or y[2:0]==0).
module vga_frame_scanner #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int CELL_SHIFT = 3
) (
   input logic              clk,
   input logic              rst_n,
   vga_frame_scanner_if.slave bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int COLS    = H_ACTIVE >> CELL_SHIFT;
   localparam int ROWS    = V_ACTIVE >> CELL_SHIFT;
   localparam int CELLS   = COLS * ROWS;
   localparam int AW      = $clog2(CELLS);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [6:0]    COLS_X = 7'(COLS);
   localparam logic [5:0]    ROWS_Y = 6'(ROWS);
   localparam logic [AW-1:0] COLS_A = AW'(COLS);

   logic          tick;
   logic [9:0]    hcount;
   logic [9:0]    vcount;

   logic [AW-1:0] addr1;
   logic          act1;
   logic          hs1;
   logic          vs1;
`ifdef VGA_GRID_EN
   logic          grid1;
`endif

   logic          hs_q;
   logic          vs_q;
   logic [2:0]    rgb_q;
   logic          frame_start_q;

   logic [2:0]    mem [0:CELLS-1];
   logic [2:0]    cell_rd;
   logic [AW-1:0] wr_addr;
   logic          wr_ok;
   logic [AW-1:0] scan_addr;

   assign scan_addr = AW'(vcount >> CELL_SHIFT) * COLS_A + AW'(hcount >> CELL_SHIFT);

   assign wr_ok   = (bus.wr_x < COLS_X) && (bus.wr_y < ROWS_Y);
   assign wr_addr = AW'(bus.wr_y) * COLS_A + AW'(bus.wr_x);

   // rst_n gates the write so strobes arriving while held in reset are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && bus.wr_en && wr_ok) begin
         mem[wr_addr] <= bus.wr_color;
      end
   end

   // Nonblocking write above means a same-edge read of that cell sees the old colour.
   assign cell_rd = mem[addr1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick          <= 1'b0;
         hcount        <= '0;
         vcount        <= '0;
         addr1         <= '0;
         act1          <= 1'b0;
         hs1           <= 1'b1;
         vs1           <= 1'b1;
`ifdef VGA_GRID_EN
         grid1         <= 1'b0;
`endif
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         rgb_q         <= 3'b000;
         frame_start_q <= 1'b0;
      end else begin
         tick          <= ~tick;
         frame_start_q <= tick && (hcount == H_LAST) && (vcount == V_LAST);
         if (tick) begin
            if (hcount == H_LAST) begin
               hcount <= '0;
               vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
               hcount <= hcount + 10'd1;
            end

            addr1 <= scan_addr;
            act1  <= (hcount < H_ACT) && (vcount < V_ACT);
            hs1   <= !((hcount >= HS_BEG) && (hcount < HS_END));
            vs1   <= !((vcount >= VS_BEG) && (vcount < VS_END));
`ifdef VGA_GRID_EN
            grid1 <= (hcount[CELL_SHIFT-1:0] == '0) || (vcount[CELL_SHIFT-1:0] == '0);
`endif

            hs_q <= hs1;
            vs_q <= vs1;
`ifdef VGA_GRID_EN
            rgb_q <= !act1 ? 3'b000 : (grid1 ? 3'b111 : cell_rd);
`else
            rgb_q <= act1 ? cell_rd : 3'b000;
`endif
         end
      end
   end

   assign bus.vga_hs      = hs_q;
   assign bus.vga_vs      = vs_q;
   assign bus.vga_r       = rgb_q[2];
   assign bus.vga_g       = rgb_q[1];
   assign bus.vga_b       = rgb_q[0];
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner
// Directed bench for vga_frame_scanner. The vertical timing is shortened
// (16 active lines, FP 1, sync 2, BP 1 -> 20 lines, 16000 ticks per frame) so
// whole frames fit in a short run; horizontal timing and cell mapping are the
// real 640-pixel ones. The bench tracks clocks since reset release: the output
// after clock edge n shows scan position floor(n/2)-2.
module tb_vga_frame_scanner;

   localparam int FRAME = 16000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #10 clk = ~clk;

   vga_frame_scanner_if bus ();

   vga_frame_scanner #(
      .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] expc(input int x, input int y, input logic [2:0] c);
`ifdef VGA_GRID_EN
      if ((x % 8 == 0) || (y % 8 == 0)) return 3'b111;
`endif
      return c;
   endfunction

   function automatic logic [2:0] rgb();
      return {bus.vga_r, bus.vga_g, bus.vga_b};
   endfunction

   task automatic goto_px(input int x, input int y, input int base);
      int n;
      n = 2 * (base + y * 800 + x + 2);
      if (cyc >= n) check_val("late", cyc, n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic pix(input string tag, input int x, input int y, input int base,
                      input logic [2:0] exp);
      goto_px(x, y, base);
      check_val(tag, rgb(), exp);
   endtask

   task automatic wr(input int x, input int y, input logic [2:0] c);
      @(negedge clk);
      bus.wr_en    = 1'b1;
      bus.wr_x     = 7'(x);
      bus.wr_y     = 6'(y);
      bus.wr_color = c;
      @(negedge clk);
      bus.wr_en    = 1'b0;
   endtask

   task automatic wait_frame_start(input string tag);
      while (!bus.frame_start && cyc < 40000) @(negedge clk);
      check_val(tag, cyc, 32000);
      if (bus.frame_start) begin
         @(negedge clk);
         check_val({tag, "_width"}, bus.frame_start, 1'b0);
      end
   endtask

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_x     = '0;
      bus.wr_y     = '0;
      bus.wr_color = '0;

      repeat (3) @(negedge clk);
      check_val("rst_hs", bus.vga_hs, 1'b1);
      check_val("rst_vs", bus.vga_vs, 1'b1);
      check_val("rst_rgb", rgb(), 3'b000);
      check_val("rst_fs", bus.frame_start, 1'b0);
      rst_n = 1'b1;

      // frame 0: clear the visible cells, then load the test pattern
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 80; x++)
            wr(x, y, 3'b000);
      wr(0, 0, 3'b010);
      wr(79, 1, 3'b100);
      wr(80, 0, 3'b111);
      wr(3, 60, 3'b111);

      goto_px(655, 3, 0); check_val("hs_655", bus.vga_hs, 1'b1);
      goto_px(656, 3, 0); check_val("hs_656", bus.vga_hs, 1'b0);
      goto_px(751, 3, 0); check_val("hs_751", bus.vga_hs, 1'b0);
      goto_px(752, 3, 0); check_val("hs_752", bus.vga_hs, 1'b1);
      goto_px(799, 16, 0); check_val("vs_l16", bus.vga_vs, 1'b1);
      goto_px(0, 17, 0);   check_val("vs_l17", bus.vga_vs, 1'b0);
      goto_px(799, 18, 0); check_val("vs_l18", bus.vga_vs, 1'b0);
      goto_px(0, 19, 0);   check_val("vs_l19", bus.vga_vs, 1'b1);

      wait_frame_start("fs_first");

      // frame 1: pattern readback
      pix("px_0_0",   0,   0, FRAME, expc(0, 0, 3'b010));
      pix("px_7_0",   7,   0, FRAME, expc(7, 0, 3'b010));
      pix("px_8_0",   8,   0, FRAME, expc(8, 0, 3'b000));
      pix("px_639_0", 639, 0, FRAME, expc(639, 0, 3'b000));
      pix("blank_640", 640, 0, FRAME, 3'b000);

      // write cell 12 on the very edge that reads it for pixel (100,2)
      while (cyc < 2 * (FRAME + 2 * 800 + 100 + 2) - 1) @(negedge clk);
      bus.wr_en    = 1'b1;
      bus.wr_x     = 7'd12;
      bus.wr_y     = 6'd0;
      bus.wr_color = 3'b011;
      @(negedge clk);
      bus.wr_en    = 1'b0;
      check_val("same_cycle_old", rgb(), expc(100, 2, 3'b000));
      pix("same_cycle_new", 101, 2, FRAME, expc(101, 2, 3'b011));

      pix("px_0_7",   0,   7, FRAME, expc(0, 7, 3'b010));
      pix("px_7_7",   7,   7, FRAME, expc(7, 7, 3'b010));
      pix("discard_x80", 0, 8, FRAME, expc(0, 8, 3'b000));
      pix("px_631_8", 631, 8, FRAME, expc(631, 8, 3'b000));
      pix("px_632_8", 632, 8, FRAME, expc(632, 8, 3'b100));
      pix("px_639_8", 639, 8, FRAME, expc(639, 8, 3'b100));

      // reset with the counters at h=300, v=9, with a write held during reset
      while (cyc < 47000) @(negedge clk);
      rst_n        = 1'b0;
      bus.wr_en    = 1'b1;
      bus.wr_x     = 7'd0;
      bus.wr_y     = 6'd0;
      bus.wr_color = 3'b111;
      #1;
      check_val("mid_rst_hs", bus.vga_hs, 1'b1);
      check_val("mid_rst_vs", bus.vga_vs, 1'b1);
      check_val("mid_rst_rgb", rgb(), 3'b000);
      check_val("mid_rst_fs", bus.frame_start, 1'b0);
      repeat (3) @(negedge clk);
      bus.wr_en = 1'b0;
      rst_n     = 1'b1;

      pix("after_rst_0_0",   0,   0, 0, expc(0, 0, 3'b010));
      pix("after_rst_100_0", 100, 0, 0, expc(100, 0, 3'b011));
      goto_px(656, 0, 0); check_val("after_rst_hs", bus.vga_hs, 1'b0);
      pix("after_rst_632_8", 632, 8, 0, expc(632, 8, 3'b100));

      wait_frame_start("fs_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
